core_read_arbiter: RTL and testbench
====================================

Name: core_read_arbiter

Overview:
- Shares one Avalon read-only master port between NUM_REQ core read masters, e.g. the two image-line fetchers that run when the top FSM sets Share_i.
- Round-robin arbitration with lock-aware grant hold: a requester holding Lock keeps the bus for its whole burst of Height lines.
- Sits between the read masters and the Avalon interconnect.
- Read data is broadcast. The arbiter only steers address, control and waitrequest.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ADDR_W, 64, Avalon address width.
- DATA_W, 1024, Avalon read-data width.
- TIMEOUT_CYC, 1024, grant watchdog limit in cycles (used only with ARB_TIMEOUT_EN).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- ReqAddr_i  in  NUM_REQ*ADDR_W  packed requester addresses; requester k uses bits [k*ADDR_W +: ADDR_W].
- ReqRead_i  in  NUM_REQ  per-requester read.
- ReqLock_i  in  NUM_REQ  per-requester lock (burst hold).
- ReqWaitReq_o  out  NUM_REQ  per-requester waitrequest.
- ReqReadData_o  out  DATA_W  broadcast read data.
- AvalonAddr_o  out  ADDR_W  master address.
- AvalonRead_o  out  1  master read.
- AvalonLock_o  out  1  master lock.
- AvalonReadData_i  in  DATA_W  slave read data.
- AvalonWaitReq_i  in  1  slave waitrequest.
- Grant_o  out  NUM_REQ  one-hot current grant; zero when idle.
- Timeout_o  out  1  sticky watchdog flag (tied 0 without ARB_TIMEOUT_EN).

Behaviour:
- Reset (rst=1 at a clk edge) forces:
  - FSM to IDLE, Grant_o=0, round-robin pointer Last=NUM_REQ-1 (so requester 0 has top priority next), Timeout_o=0.
  - AvalonRead_o=0, AvalonLock_o=0, AvalonAddr_o=0.
  - ReqWaitReq_o all ones.
- Reset mid-burst: the grant is dropped in the same edge; no transfer is issued in the following cycle.
- FSM state IDLE:
  - All ReqWaitReq_o=1; AvalonRead_o=0.
  - If any ReqRead_i is high, the winner is the first set bit searching from Last+1 upward, modulo NUM_REQ.
  - Grant is registered at the edge; FSM moves to GRANT. Arbitration latency is 1 cycle.
  - With no request, stay in IDLE.
- FSM state GRANT, requester g granted:
  - AvalonAddr_o=ReqAddr_i[g], AvalonRead_o=ReqRead_i[g], AvalonLock_o=ReqLock_i[g], all combinational pass-through.
  - ReqWaitReq_o[g]=AvalonWaitReq_i; every other bit is 1.
- Release from GRANT to IDLE, Last<=g, Grant_o<=0 at the edge, when either holds:
  - (a) ReqRead_i[g]=0 and ReqLock_i[g]=0;
  - (b) ReqLock_i[g]=0 and an accepted transfer occurs (ReqRead_i[g]=1 & AvalonWaitReq_i=0). Unlocked single reads are re-arbitrated after every beat.
- While ReqLock_i[g]=1, the grant is held even if ReqRead_i[g] drops for a cycle (halt bubbles).
- No zero-idle-cycle back-to-back grant: every release passes through IDLE for one cycle, even with other requests pending.
- Data path:
  - ReqReadData_o=AvalonReadData_i, combinational, unregistered.
  - Requesters qualify data themselves with their registered ~waitrequest.
- Fairness: in steady contention, each requester receives at most one locked burst before every other waiting requester is granted.
- Simultaneous events:
  - A new request arriving in the release cycle is considered at the next IDLE evaluation.
  - A request withdrawn in IDLE before the edge is not granted.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- When defined:
  - A counter counts cycles spent in GRANT; it is cleared on every grant and on every accepted transfer.
  - When it reaches TIMEOUT_CYC-1, the grant is forcibly released to IDLE with Last<=g, and Timeout_o is set.
  - Timeout_o stays set until rst.
- When undefined: no counter, Timeout_o tied 0, grant held indefinitely under lock.

Test Plan (NUM_REQ=2):
1. Reset release, no requests -> Grant_o=0, ReqWaitReq_o=2'b11, AvalonRead_o=0 for 10 cycles.
2. Req0 only, Lock=1, Read=1, 4 beats at addresses 0x0..0x3, AvalonWaitReq_i=0 -> Grant_o=2'b01 one cycle after Read; AvalonAddr_o sequences 0..3; ReqWaitReq_o=2'b10; release on Lock=0/Read=0.
3. Both request at the same edge from reset -> Req0 granted first; on its release, one IDLE cycle, then Grant_o=2'b10.
4. Req1 locked burst with AvalonWaitReq_i high for 3 cycles mid-burst and ReqRead_i[1] dropped 1 cycle (halt) -> grant held; ReqWaitReq_o[1] mirrors slave; Req0 sees waitreq=1 throughout.
5. Unlocked single reads from both requesters continuously -> grants alternate 01,10,01,... one beat each.
6. rst asserted mid-burst; separately, with ARB_TIMEOUT_EN and TIMEOUT_CYC=8, AvalonWaitReq_i stuck high -> rst: Grant_o=0 next cycle. Timeout: forced release after 8 cycles, Timeout_o=1, other requester granted next.

Source files
------------

// File: rtl/core_read_arbiter.sv
// Round-robin, lock-aware arbiter sharing one Avalon read master port.
// Optional grant watchdog enabled by defining ARB_TIMEOUT_EN.
module core_read_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int ADDR_W      = 64,
  parameter int DATA_W      = 1024,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ*ADDR_W-1:0] ReqAddr_i,
  input  logic [NUM_REQ-1:0]        ReqRead_i,
  input  logic [NUM_REQ-1:0]        ReqLock_i,
  output logic [NUM_REQ-1:0]        ReqWaitReq_o,
  output logic [DATA_W-1:0]         ReqReadData_o,
  output logic [ADDR_W-1:0]         AvalonAddr_o,
  output logic                      AvalonRead_o,
  output logic                      AvalonLock_o,
  input  logic [DATA_W-1:0]         AvalonReadData_i,
  input  logic                      AvalonWaitReq_i,
  output logic [NUM_REQ-1:0]        Grant_o,
  output logic                      Timeout_o
);

  localparam int IW = $clog2(NUM_REQ);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t        state, state_nx;
  logic [IW-1:0] gidx, gidx_nx;
  logic [IW-1:0] last, last_nx;
  logic [IW-1:0] win;
  logic          found;
  logic          rd, lk, acc, rel, tmo;

  logic [ADDR_W-1:0] addr_arr [NUM_REQ];

  always_comb begin
    for (int k = 0; k < NUM_REQ; k++) begin
      addr_arr[k] = ReqAddr_i[k*ADDR_W +: ADDR_W];
    end
  end

  // Search starts just past the last owner and wraps around.
  always_comb begin
    int            idx;
    logic [IW-1:0] cand;
    found = 1'b0;
    win   = '0;
    idx   = 0;
    cand  = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = int'(last) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      cand = IW'(idx);
      if (!found && ReqRead_i[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  assign rd  = ReqRead_i[gidx];
  assign lk  = ReqLock_i[gidx];
  assign acc = rd & ~AvalonWaitReq_i;
  assign rel = ~lk & (~rd | acc);

  always_comb begin
    state_nx = state;
    gidx_nx  = gidx;
    last_nx  = last;
    unique case (state)
      IDLE: begin
        if (found) begin
          state_nx = GRANT;
          gidx_nx  = win;
        end
      end
      GRANT: begin
        if (rel || tmo) begin
          state_nx = IDLE;
          last_nx  = gidx;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      gidx  <= '0;
      last  <= IW'(NUM_REQ - 1);
    end else begin
      state <= state_nx;
      gidx  <= gidx_nx;
      last  <= last_nx;
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC) + 1;

  logic [CW-1:0] cnt;
  logic          tflag;

  // An accepted beat proves progress, so it also restarts the watchdog.
  assign tmo = (state == GRANT) && (cnt == CW'(TIMEOUT_CYC - 1))
             && !acc && !rel;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      tflag <= 1'b0;
    end else begin
      if (state != GRANT || acc) cnt <= '0;
      else                       cnt <= cnt + CW'(1);
      if (tmo) tflag <= 1'b1;
    end
  end

  assign Timeout_o = tflag;
`else
  localparam int unused_timeout = TIMEOUT_CYC;

  assign tmo       = 1'b0;
  assign Timeout_o = 1'b0;
`endif

  always_comb begin
    Grant_o      = '0;
    ReqWaitReq_o = '1;
    AvalonAddr_o = '0;
    AvalonRead_o = 1'b0;
    AvalonLock_o = 1'b0;
    if (state == GRANT) begin
      Grant_o[gidx]      = 1'b1;
      ReqWaitReq_o[gidx] = AvalonWaitReq_i;
      AvalonAddr_o       = addr_arr[gidx];
      AvalonRead_o       = rd;
      AvalonLock_o       = lk;
    end
  end

  assign ReqReadData_o = AvalonReadData_i;

endmodule

// File: tb/tb_core_read_arbiter.sv
// Directed bench for core_read_arbiter with NUM_REQ=2.
// Watchdog steps run only when ARB_TIMEOUT_EN is defined.
module tb_core_read_arbiter;

  localparam int NR = 2;
  localparam int AW = 16;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] addr0, addr1;
  logic [NR*AW-1:0] req_addr;
  logic [NR-1:0] req_read, req_lock;
  logic [NR-1:0] req_wait;
  logic [DW-1:0] req_data;
  logic [AW-1:0] av_addr;
  logic          av_read, av_lock;
  logic [DW-1:0] av_data;
  logic          av_wait;
  logic [NR-1:0] grant;
  logic          timeout;

  int checks   = 0;
  int failures = 0;

  assign req_addr = {addr1, addr0};

  always #5 clk = ~clk;

  core_read_arbiter #(
    .NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ReqAddr_i(req_addr),
    .ReqRead_i(req_read),
    .ReqLock_i(req_lock),
    .ReqWaitReq_o(req_wait),
    .ReqReadData_o(req_data),
    .AvalonAddr_o(av_addr),
    .AvalonRead_o(av_read),
    .AvalonLock_o(av_lock),
    .AvalonReadData_i(av_data),
    .AvalonWaitReq_i(av_wait),
    .Grant_o(grant),
    .Timeout_o(timeout)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    settle();
  endtask

  logic [NR-1:0] alt_exp [6];

  initial begin
    rst      = 1'b1;
    addr0    = '0;
    addr1    = '0;
    req_read = '0;
    req_lock = '0;
    av_data  = '0;
    av_wait  = 1'b0;
    do_reset();

    chk("rst_timeout", 64'(timeout), 64'h0);
    chk("rst_lock", 64'(av_lock), 64'h0);
    chk("rst_addr", 64'(av_addr), 64'h0);
    for (int i = 0; i < 10; i++) begin
      chk("idle_grant", 64'(grant), 64'h0);
      chk("idle_wait", 64'(req_wait), 64'h3);
      chk("idle_read", 64'(av_read), 64'h0);
      tick();
    end

    av_data = 32'hCAFE_F00D;
    settle();
    chk("data_bcast", 64'(req_data), 64'hCAFE_F00D);

    // Locked 4-beat burst from requester 0
    req_read = 2'b01;
    req_lock = 2'b01;
    settle();
    chk("arb_latency", 64'(grant), 64'h0);
    tick();
    chk("b0_grant", 64'(grant), 64'h1);
    chk("b0_read", 64'(av_read), 64'h1);
    chk("b0_lock", 64'(av_lock), 64'h1);
    for (int b = 0; b < 4; b++) begin
      addr0 = AW'(b);
      settle();
      chk("b0_addr", 64'(av_addr), 64'(b));
      chk("b0_wait", 64'(req_wait), 64'h2);
      chk("b0_hold", 64'(grant), 64'h1);
      tick();
    end
    req_read = 2'b00;
    req_lock = 2'b00;
    settle();
    chk("b0_last", 64'(grant), 64'h1);
    tick();
    chk("b0_release", 64'(grant), 64'h0);
    chk("b0_rel_wait", 64'(req_wait), 64'h3);

    // Simultaneous requests from reset: requester 0 wins
    do_reset();
    addr0    = 16'h1000;
    addr1    = 16'h2000;
    req_read = 2'b11;
    req_lock = 2'b11;
    tick();
    chk("both_first", 64'(grant), 64'h1);
    chk("both_wait", 64'(req_wait), 64'h2);
    chk("both_addr", 64'(av_addr), 64'h1000);
    tick();
    chk("both_hold", 64'(grant), 64'h1);
    req_read = 2'b10;
    req_lock = 2'b10;
    tick();
    chk("both_gap", 64'(grant), 64'h0);
    chk("both_gap_wait", 64'(req_wait), 64'h3);
    tick();
    chk("both_second", 64'(grant), 64'h2);
    chk("both_addr1", 64'(av_addr), 64'h2000);

    // Requester 1 burst with slave stalls and a halt bubble
    req_read = 2'b11;
    req_lock = 2'b10;
    av_wait  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("stall_wait", 64'(req_wait), 64'h3);
      tick();
      chk("stall_hold", 64'(grant), 64'h2);
    end
    av_wait = 1'b0;
    settle();
    chk("go_wait", 64'(req_wait), 64'h1);
    tick();
    req_read = 2'b01;
    settle();
    chk("halt_read", 64'(av_read), 64'h0);
    chk("halt_wait0", 64'(req_wait[0]), 64'h1);
    tick();
    chk("halt_hold", 64'(grant), 64'h2);
    req_read = 2'b11;
    req_lock = 2'b00;
    tick();
    chk("b1_release", 64'(grant), 64'h0);

    // Unlocked single reads from both alternate
    tick();
    chk("rr_first", 64'(grant), 64'h1);
    alt_exp[0] = 2'b00;
    alt_exp[1] = 2'b10;
    alt_exp[2] = 2'b00;
    alt_exp[3] = 2'b01;
    alt_exp[4] = 2'b00;
    alt_exp[5] = 2'b10;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("rr_alt", 64'(grant), 64'(alt_exp[i]));
    end

    // Reset mid-burst drops the grant at that edge
    do_reset();
    req_read = 2'b01;
    req_lock = 2'b01;
    tick();
    tick();
    chk("mid_grant", 64'(grant), 64'h1);
    rst = 1'b1;
    tick();
    chk("mid_rst_grant", 64'(grant), 64'h0);
    chk("mid_rst_read", 64'(av_read), 64'h0);
    chk("mid_rst_wait", 64'(req_wait), 64'h3);
    rst = 1'b0;
    tick();
    chk("mid_regrant", 64'(grant), 64'h1);

`ifdef ARB_TIMEOUT_EN
    do_reset();
    req_read = 2'b11;
    req_lock = 2'b01;
    av_wait  = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      chk("wd_hold", 64'(grant), 64'h1);
      chk("wd_flag_low", 64'(timeout), 64'h0);
      tick();
    end
    chk("wd_release", 64'(grant), 64'h0);
    chk("wd_flag", 64'(timeout), 64'h1);
    tick();
    chk("wd_next", 64'(grant), 64'h2);
    chk("wd_sticky", 64'(timeout), 64'h1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
